// File: rtl/axi_sts_read_arbiter_pkg.sv
// Shared types, response codes and sizing helper for the status read arbiter.
package axi_sts_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axi_sts_read_arbiter_if.sv
// AXI4-Lite read-only channel bundle (AR + R) with master/slave views.
interface axi_sts_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import axi_sts_read_arbiter_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  resp_t             rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_sts_read_arbiter_rr_grant2.sv
// Two-way round-robin grant: one-hot grant, the requester other than `last` wins a tie.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module axi_rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_sts_read_arbiter.sv
// Shares one AXI4-Lite status-register read slave between two read masters, one transaction in flight.
// Latency: grant at cycle 0, slave AR at 1, answer at 2 earliest, requester R at 3; 4 cycles between grants.
// Backpressure: AR held until m_axi_arready; R held until the granted rready; a silent slave times out to SLVERR.
module axi_sts_read_arbiter
  import axi_sts_read_arbiter_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT        = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi_sts_read_arbiter_if.slave  s0_axi,
  axi_sts_read_arbiter_if.slave  s1_axi,
  axi_sts_read_arbiter_if.master m_axi,
  output logic [7:0]             timeout_count
);

  localparam int              CNT_W    = clogb2(TIMEOUT + 1);
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic                      gnt_id_q, gnt_id_d;
  logic                      last_q, last_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                     rresp_q, rresp_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [7:0]                tmo_q, tmo_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel_rready;
  logic       in_idle, in_addr, in_wait, in_resp;

  assign req        = {s1_axi.arvalid, s0_axi.arvalid};
  assign sel_rready = gnt_id_q ? s1_axi.rready : s0_axi.rready;

  axi_rr_grant2 u_grant (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          gnt_id_d = gnt[1];
          addr_d   = gnt[1] ? s1_axi.araddr : s0_axi.araddr;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (m_axi.arready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A real answer wins over a timeout landing in the same cycle.
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          rresp_d = m_axi.rresp;
          state_d = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          if (tmo_q != 8'hFF) begin
            tmo_d = tmo_q + 8'd1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (sel_rready) begin
          last_d  = gnt_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      gnt_id_q <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign in_idle = (state_q == IDLE);
  assign in_addr = (state_q == ADDR);
  assign in_wait = (state_q == WAIT);
  assign in_resp = (state_q == RESP);

  // Grant and IDLE rready follow live inputs, so gate them while reset is held.
  assign s0_axi.arready = aresetn & in_idle & gnt[0];
  assign s1_axi.arready = aresetn & in_idle & gnt[1];

  assign s0_axi.rvalid = in_resp & ~gnt_id_q;
  assign s0_axi.rdata  = (in_resp & ~gnt_id_q) ? rdata_q : '0;
  assign s0_axi.rresp  = (in_resp & ~gnt_id_q) ? rresp_q : RESP_OKAY;

  assign s1_axi.rvalid = in_resp & gnt_id_q;
  assign s1_axi.rdata  = (in_resp & gnt_id_q) ? rdata_q : '0;
  assign s1_axi.rresp  = (in_resp & gnt_id_q) ? rresp_q : RESP_OKAY;

  assign m_axi.arvalid = in_addr;
  assign m_axi.araddr  = in_addr ? addr_q : '0;
  assign m_axi.rready  = aresetn & (in_idle | in_wait);

  assign timeout_count = tmo_q;

endmodule
